// File: rtl/prcap_cfg_ctrl.sv
// prcap_cfg_ctrl: configuration loader for a pseudo red cell cap row.
// The host streams one 4-bit code per column (column 0 first). Once every
// column is loaded, the controller runs SETUP / STROBE / HOLD to clock the
// codes into the cap row, then releases the array into RUN. In RUN the cap
// row data_in is fed from the logic-analyzer bus instead.
//
// Optional feature macro: PRCAP_CFG_READBACK_EN adds the cfg_shadow output,
// a copy of the configuration captured on every entry to RUN.
module prcap_cfg_ctrl #(
    parameter int BLOCKWIDTH = 8,
    parameter int CNTW       = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_valid,
    input  logic [3:0]              cfg_nibble,
    output logic                    cfg_ready,
    input  logic                    cfg_abort,
    input  logic                    reconf_req,
    input  logic [4*BLOCKWIDTH-1:0] run_data,
    output logic                    arr_reset,
    output logic                    rconfclk,
    output logic [4*BLOCKWIDTH-1:0] arr_data_in,
`ifdef PRCAP_CFG_READBACK_EN
    output logic [4*BLOCKWIDTH-1:0] cfg_shadow,
`endif
    output logic                    cfg_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_RUN    = 3'd5
    } state_t;

    localparam logic [CNTW-1:0] COL_LAST = CNTW'(BLOCKWIDTH - 1);

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNTW-1:0]         col_cnt_reg;
    logic [CNTW-1:0]         col_cnt_next;
    logic                    wr_en;
    logic [4*BLOCKWIDTH-1:0] shift_reg;
    logic [4*BLOCKWIDTH-1:0] shift_next;
    logic                    cfg_ready_reg;
    logic                    rconfclk_reg;
    logic                    cfg_done_reg;
    logic                    arr_reset_reg;

    // State and column counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            col_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            col_cnt_reg <= col_cnt_next;
        end
    end

    // Next-state logic; abort beats a simultaneous handshake, which then writes nothing
    always_comb begin
        state_next   = state_reg;
        col_cnt_next = col_cnt_reg;
        wr_en        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_next   = ST_IDLE;
                    col_cnt_next = '0;
                end else if (cfg_valid && cfg_ready_reg) begin
                    wr_en = 1'b1;
                    if (col_cnt_reg == COL_LAST) begin
                        state_next   = ST_SETUP;
                        col_cnt_next = '0;
                    end else begin
                        col_cnt_next = col_cnt_reg + 1'b1;
                    end
                end
            end
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_RUN;
            ST_RUN: begin
                if (reconf_req) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                col_cnt_next = '0;
            end
        endcase
    end

    // Per-column write steering: only the addressed slot takes the new nibble
    for (genvar gi = 0; gi < BLOCKWIDTH; gi++) begin : g_slot
        assign shift_next[4*gi +: 4] = (wr_en && (col_cnt_reg == CNTW'(gi)))
                                       ? cfg_nibble : shift_reg[4*gi +: 4];
    end

    // Configuration shift register; writes only happen in LOAD so it is stable through the strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_next;
        end
    end

    // Control outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_ready_reg <= 1'b0;
            rconfclk_reg  <= 1'b0;
            cfg_done_reg  <= 1'b0;
            arr_reset_reg <= 1'b1;
        end else begin
            cfg_ready_reg <= (state_next == ST_LOAD);
            rconfclk_reg  <= (state_next == ST_STROBE);
            cfg_done_reg  <= (state_next == ST_RUN);
            arr_reset_reg <= (state_next != ST_RUN);
        end
    end

`ifdef PRCAP_CFG_READBACK_EN
    logic [4*BLOCKWIDTH-1:0] shadow_reg;

    // Snapshot of the configuration taken as the array enters RUN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_reg <= '0;
        end else if ((state_next == ST_RUN) && (state_reg != ST_RUN)) begin
            shadow_reg <= shift_reg;
        end
    end

    assign cfg_shadow = shadow_reg;
`endif

    assign cfg_ready   = cfg_ready_reg;
    assign rconfclk    = rconfclk_reg;
    assign cfg_done    = cfg_done_reg;
    assign arr_reset   = arr_reset_reg;
    assign arr_data_in = (state_reg == ST_RUN) ? run_data : shift_reg;

endmodule

// File: tb/tb_prcap_cfg_ctrl.sv
// tb_prcap_cfg_ctrl: directed plus randomized bench for prcap_cfg_ctrl.
// The reference model keeps the configured column codes as an array and the
// expected strobe timeline as a fixed sequence of cycles after the last code.
module tb_prcap_cfg_ctrl;

    localparam int BW = 8;
    localparam int DW = 4 * BW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_valid;
    logic [3:0]    cfg_nibble;
    logic          cfg_ready;
    logic          cfg_abort;
    logic          reconf_req;
    logic [DW-1:0] run_data;
    logic          arr_reset;
    logic          rconfclk;
    logic [DW-1:0] arr_data_in;
    logic          cfg_done;
`ifdef PRCAP_CFG_READBACK_EN
    logic [DW-1:0] cfg_shadow;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0]    m_col [BW];
    logic [DW-1:0] m_shadow;
    logic [DW-1:0] strobe_data;
    int            strobe_pulses;

    prcap_cfg_ctrl #(.BLOCKWIDTH(BW), .CNTW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_nibble (cfg_nibble),
        .cfg_ready  (cfg_ready),
        .cfg_abort  (cfg_abort),
        .reconf_req (reconf_req),
        .run_data   (run_data),
        .arr_reset  (arr_reset),
        .rconfclk   (rconfclk),
        .arr_data_in(arr_data_in),
`ifdef PRCAP_CFG_READBACK_EN
        .cfg_shadow (cfg_shadow),
`endif
        .cfg_done   (cfg_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] model_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < BW; i++) w = w | (DW'(m_col[i]) << (4 * i));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic chk_shadow(input string tag);
`ifdef PRCAP_CFG_READBACK_EN
        chk(tag, 64'(cfg_shadow), 64'(m_shadow));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20; k++) begin
            if (cfg_ready === 1'b1) return;
            @(negedge clk);
        end
        chk("ready_timeout", 64'(cfg_ready), 64'd1);
    endtask

    // Load one configuration word. toggle: 0 none, 1 alternate gaps, 2 random gaps.
    // abort_at >= 0 raises cfg_abort with that handshake. rst_strobe resets during STROBE.
    task automatic load_word(input logic [DW-1:0] w, input int toggle, input int abort_at,
                             input bit rst_strobe);
        int  i = 0;
        bit  last_gap = 1'b1;
        logic [3:0] nib;
        wait_ready();
        while (i < BW) begin
            if ((toggle == 1 && !last_gap) || (toggle == 2 && $urandom_range(0, 1) == 1)) begin
                cfg_valid  = 1'b0;
                cfg_nibble = 4'($urandom);
                reconf_req = 1'($urandom_range(0, 1));
                last_gap   = 1'b1;
                @(negedge clk);
                chk("gap_ready", 64'(cfg_ready), 64'd1);
                chk("gap_no_strobe", 64'(rconfclk), 64'd0);
                continue;
            end
            last_gap   = 1'b0;
            nib        = w[4*i +: 4];
            cfg_valid  = 1'b1;
            cfg_nibble = nib;
            cfg_abort  = (i == abort_at);
            reconf_req = 1'b0;
            @(negedge clk);
            if (i == abort_at) begin
                cfg_abort = 1'b0;
                cfg_valid = 1'b0;
                chk("abort_idle_ready", 64'(cfg_ready), 64'd0);
                chk("abort_no_write", 64'(arr_data_in), 64'(model_word()));
                chk("abort_arr_reset", 64'(arr_reset), 64'd1);
                $display("load aborted at handshake %0d", i);
                return;
            end
            m_col[i] = nib;
            i++;
            if (i < BW) begin
                chk("load_ready", 64'(cfg_ready), 64'd1);
                chk("load_no_strobe", 64'(rconfclk), 64'd0);
            end
        end
        // SETUP: valid stays high with junk to show it is ignored while not ready
        cfg_nibble    = 4'($urandom);
        reconf_req    = 1'b1;
        cfg_abort     = 1'($urandom_range(0, 1));
        strobe_pulses = 0;
        chk("setup_rconfclk", 64'(rconfclk), 64'd0);
        chk("setup_ready", 64'(cfg_ready), 64'd0);
        chk("setup_arr_reset", 64'(arr_reset), 64'd1);
        chk("setup_data", 64'(arr_data_in), 64'(model_word()));
        chk_shadow("setup_shadow");
        @(negedge clk);
        if (rconfclk === 1'b1) strobe_pulses++;
        strobe_data = arr_data_in;
        chk("strobe_rconfclk", 64'(rconfclk), 64'd1);
        chk("strobe_data", 64'(arr_data_in), 64'(model_word()));
        chk("strobe_done", 64'(cfg_done), 64'd0);
        chk_shadow("strobe_shadow");
        if (rst_strobe) begin
            reset_n   = 1'b0;
            cfg_valid = 1'b0;
            cfg_abort = 1'b0;
            reconf_req = 1'b0;
            @(negedge clk);
            for (int k = 0; k < BW; k++) m_col[k] = 4'h0;
            m_shadow = '0;
            chk("rst_strobe_rconfclk", 64'(rconfclk), 64'd0);
            chk("rst_strobe_arr_reset", 64'(arr_reset), 64'd1);
            chk("rst_strobe_ready", 64'(cfg_ready), 64'd0);
            chk("rst_strobe_done", 64'(cfg_done), 64'd0);
            chk("rst_strobe_data", 64'(arr_data_in), 64'(model_word()));
            reset_n = 1'b1;
            @(negedge clk);
            chk("rst_strobe_idle_to_load", 64'(cfg_ready), 64'd1);
            $display("reset during strobe applied");
            return;
        end
        @(negedge clk);
        if (rconfclk === 1'b1) strobe_pulses++;
        chk("hold_rconfclk", 64'(rconfclk), 64'd0);
        chk("hold_data", 64'(arr_data_in), 64'(model_word()));
        chk_shadow("hold_shadow");
        @(negedge clk);
        cfg_valid  = 1'b0;
        cfg_abort  = 1'b0;
        reconf_req = 1'b0;
        m_shadow   = model_word();
        chk("strobe_pulse_count", 64'(strobe_pulses), 64'd1);
        chk("run_done", 64'(cfg_done), 64'd1);
        chk("run_arr_reset", 64'(arr_reset), 64'd0);
        chk("run_rconfclk", 64'(rconfclk), 64'd0);
        chk("run_data_mux", 64'(arr_data_in), 64'(run_data));
        chk_shadow("run_shadow");
        $display("configured word %08h, strobe data %08h", w, strobe_data);
    endtask

    // In RUN: drive run_data, poke ignored abort, then request reconfiguration
    task automatic run_then_reconf(input logic [DW-1:0] rd);
        run_data = rd;
        #1;
        chk("run_passthrough", 64'(arr_data_in), 64'(rd));
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("run_abort_ignored", 64'(cfg_done), 64'd1);
        reconf_req = 1'b1;
        @(negedge clk);
        reconf_req = 1'b0;
        chk("reconf_arr_reset", 64'(arr_reset), 64'd1);
        chk("reconf_ready", 64'(cfg_ready), 64'd1);
        chk("reconf_done", 64'(cfg_done), 64'd0);
        chk("reconf_keeps_shift", 64'(arr_data_in), 64'(model_word()));
        chk_shadow("reconf_shadow");
        $display("run_data %08h then reconfigure", rd);
    endtask

    initial begin
        logic [DW-1:0] w;
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_nibble = 4'h0;
        cfg_abort  = 1'b0;
        reconf_req = 1'b0;
        run_data   = '0;
        m_shadow   = '0;
        for (int k = 0; k < BW; k++) m_col[k] = 4'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_arr_reset", 64'(arr_reset), 64'd1);
        chk("rst_rconfclk", 64'(rconfclk), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_data", 64'(arr_data_in), 64'd0);
        chk_shadow("rst_shadow");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_to_load", 64'(cfg_ready), 64'd1);
        $display("reset released");

        // Back-to-back load of a known pattern
        load_word(32'h84218421, 0, -1, 1'b0);
        chk("dir_strobe_word", 64'(strobe_data), 64'h84218421);
        run_then_reconf(32'hDEADBEEF);

        // Alternating valid during load
        load_word(32'h11111111, 1, -1, 1'b0);
        chk("toggle_strobe_word", 64'(strobe_data), 64'h11111111);
        run_then_reconf(32'h0BADF00D);

        // Second configuration: shadow must keep the first until this RUN entry
        load_word(32'h88888888, 2, -1, 1'b0);
        chk("second_strobe_word", 64'(strobe_data), 64'h88888888);
        run_then_reconf(32'h12345678);

        // Abort with the fifth handshake, then a full reload
        load_word(32'h33333333, 0, 4, 1'b0);
        load_word(32'h22222222, 0, -1, 1'b0);
        chk("abort_reload_word", 64'(strobe_data), 64'h22222222);
        run_then_reconf(32'hCAFEBABE);

        // Randomized configurations
        for (int r = 0; r < 8; r++) begin
            w = DW'($urandom);
            load_word(w, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BW - 1)) : -1, 1'b0);
            if (cfg_done !== 1'b1) load_word(DW'($urandom), 2, -1, 1'b0);
            run_then_reconf(DW'($urandom));
        end

        // Reset in the middle of the strobe sequence
        load_word(32'h5A5A5A5A, 0, -1, 1'b1);
        load_word(32'h76543210, 2, -1, 1'b0);
        run_then_reconf(32'hFFFF0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prcap_cfg_ctrl.md
PRCAP_CFG_CTRL -- requirements
Module: prcap_cfg_ctrl

Interface
REQ-001 SHALL have parameter BLOCKWIDTH, default 8: number of pseudo red cell columns in the controlled cap row.
REQ-002 SHALL have parameter CNTW, default 3: width of the column counter, ceil(log2(BLOCKWIDTH)).
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: synchronous active-low reset.
REQ-006 Port cfg_valid, input, 1: host offers one configuration nibble.
REQ-007 Port cfg_nibble, input, 4: {io,raw,bypass,cut} code for the current column.
REQ-008 Port cfg_ready, output, 1: controller accepts a nibble this cycle.
REQ-009 Port cfg_abort, input, 1: discard the partial load and restart.
REQ-010 Port reconf_req, input, 1: request a new configuration while running.
REQ-011 Port run_data, input, 4*BLOCKWIDTH: logic-analyzer data for cell data_in in RUN.
REQ-012 Port arr_reset, output, 1: active-high reset to the cap row and yellow array.
REQ-013 Port rconfclk, output, 1: configuration strobe to the cap row.
REQ-014 Port arr_data_in, output, 4*BLOCKWIDTH: drives the cap row data_in.
REQ-015 Port cfg_done, output, 1: high while in RUN.

Function
REQ-016 SHALL implement states IDLE, LOAD, SETUP, STROBE, HOLD and RUN.
REQ-017 SHALL move from IDLE to LOAD unconditionally on the next clock.
REQ-018 In LOAD, SHALL drive cfg_ready=1; a handshake (cfg_valid & cfg_ready) writes cfg_nibble to shift-register slot col_cnt (bits 4*col_cnt+3:4*col_cnt) and increments col_cnt.
REQ-019 The handshake at col_cnt=BLOCKWIDTH-1 SHALL move LOAD to SETUP and clear col_cnt to 0; columns load in order 0 first.
REQ-020 SETUP SHALL last one cycle with rconfclk=0; STROBE SHALL last one cycle with rconfclk=1; HOLD SHALL last one cycle with rconfclk=0; then the state SHALL be RUN.
REQ-021 arr_data_in SHALL equal the shift register in IDLE, LOAD, SETUP, STROBE and HOLD, and run_data in RUN.
REQ-022 The shift register SHALL be stable from the SETUP cycle through the HOLD cycle.
REQ-023 arr_reset SHALL be 1 in every state except RUN.
REQ-024 rconfclk, arr_reset and cfg_done SHALL be registered outputs with no combinational path from inputs.
REQ-025 In RUN, reconf_req=1 SHALL move to LOAD next cycle with arr_reset=1 and cfg_done=0 in that cycle.
REQ-026 On re-entry to LOAD, the shift register SHALL keep its previous contents until overwritten.
REQ-027 In LOAD, cfg_abort=1 SHALL return to IDLE and clear col_cnt; abort SHALL win over a simultaneous handshake, which writes nothing.
REQ-028 cfg_abort SHALL be ignored in SETUP, STROBE, HOLD and RUN; an in-flight strobe sequence always completes.
REQ-029 reconf_req SHALL be ignored outside RUN.
REQ-030 cfg_valid SHALL be ignored when cfg_ready=0.

Reset
REQ-031 When reset_n=0 at a clock edge, the block SHALL enter IDLE and set col_cnt=0, shift register=0, rconfclk=0, cfg_ready=0, cfg_done=0 and arr_reset=1.
REQ-032 A reset during STROBE SHALL drop rconfclk to 0 on that same edge.

Configuration
REQ-033 When PRCAP_CFG_READBACK_EN is defined, the block SHALL add output cfg_shadow (4*BLOCKWIDTH) that loads the shift register on entry to RUN, holds it until the next RUN entry, and resets to 0.
REQ-034 When PRCAP_CFG_READBACK_EN is undefined, the port cfg_shadow and its register SHALL not exist; all other behaviour is unchanged.

Verification
REQ-035 The bench SHALL cover this case: reset, then 8 nibbles 0x1,0x2,0x4,0x8,0x1,0x2,0x4,0x8 with cfg_valid held high -> one rconfclk pulse of exactly 1 cycle, 2 cycles after the last handshake; arr_data_in=0x84218421 across the pulse; then cfg_done=1 and arr_reset=0.
REQ-036 The bench SHALL cover this case: cfg_valid toggled 1/0 during LOAD -> exactly 8 handshakes before SETUP; no rconfclk pulse before the 8th.
REQ-037 The bench SHALL cover this case: cfg_abort together with the 5th handshake -> IDLE next cycle; a full reload of 8 x 0x2 gives arr_data_in=0x22222222 at the strobe.
REQ-038 The bench SHALL cover this case: in RUN, run_data=0xDEADBEEF -> arr_data_in=0xDEADBEEF; reconf_req=1 -> arr_reset=1 and cfg_ready=1 next cycle.
REQ-039 The bench SHALL cover this case: reset_n=0 during STROBE -> rconfclk=0 and arr_reset=1 after that edge; the state is IDLE.
REQ-040 With PRCAP_CFG_READBACK_EN defined, the bench SHALL cover this case: two configurations 0x11111111 then 0x88888888 -> cfg_shadow holds the first value until the second RUN entry.
